rice_encoder_param: RTL and testbench

RICE_ENCODER_PARAM -- requirements
Module: rice_encoder_param

---
 rtl/rice_encoder_param.sv | 172 +++++++++++++++++
 tb/tb_rice_encoder_param.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rice_encoder_param.sv
// Three-stage Rice encoder: capture, zigzag map, quotient/remainder split.
// Define RICE_BLOCK_BITS_EN to add the per-block coded-length accumulator.
module rice_encoder_param #(
  parameter int SAMPLE_W = 16,
  parameter int K_MAX    = 14,
  parameter int BLK_W    = 16
) (
  input  logic                       iClock,
  input  logic                       iReset,
  input  logic                       iValid,
  output logic                       oReady,
  input  logic signed [SAMPLE_W-1:0] iSample,
  input  logic                       iStart,
  input  logic [4:0]                 iK,
  input  logic [BLK_W-1:0]           iBlockLen,
  output logic                       oValid,
  input  logic                       iReady,
  output logic [SAMPLE_W-1:0]        oMSB,
  output logic [SAMPLE_W-1:0]        oLSB,
  output logic [4:0]                 oK,
  output logic [SAMPLE_W:0]          oBitsUsed,
  output logic                       oLast,
  output logic [31:0]                oBlockBits,
  output logic                       oBlockBitsValid
);

  localparam int         OW = SAMPLE_W + 1;
  localparam logic [4:0] KM = 5'(K_MAX);

  logic                w_adv;
  logic                w_acc;
  logic [4:0]          w_kc;
  logic [4:0]          w_k;
  logic [BLK_W-1:0]    w_len;
  logic [BLK_W-1:0]    w_cnt_n;
  logic                w_last;
  logic [SAMPLE_W-1:0] w_u;
  logic [SAMPLE_W-1:0] w_msb;
  logic [SAMPLE_W-1:0] w_lsb;
  logic [OW-1:0]       w_bits;

  logic [4:0]          r_klat;
  logic [BLK_W-1:0]    r_cnt;
  logic                r_s1_valid;
  logic [SAMPLE_W-1:0] r_s1_sample;
  logic [4:0]          r_s1_k;
  logic                r_s1_last;
  logic                r_s2_valid;
  logic [SAMPLE_W-1:0] r_s2_u;
  logic [4:0]          r_s2_k;
  logic                r_s2_last;

  // every stage moves in lockstep; a held output word freezes the pipe
  assign w_adv  = !oValid || iReady;
  assign oReady = iReset && w_adv;
  assign w_acc  = iValid && oReady;

  assign w_kc  = (iK > KM) ? KM : iK;
  assign w_len = (iBlockLen == '0) ? BLK_W'(1) : iBlockLen;

  always_comb begin
    w_k     = r_klat;
    w_last  = 1'b0;
    w_cnt_n = r_cnt;
    if (iStart) begin
      w_k     = w_kc;
      w_last  = (w_len == BLK_W'(1));
      w_cnt_n = w_len - BLK_W'(1);
    end else if (r_cnt != '0) begin
      w_last  = (r_cnt == BLK_W'(1));
      w_cnt_n = r_cnt - BLK_W'(1);
    end
  end

  assign w_u = {r_s1_sample[SAMPLE_W-2:0], 1'b0}
             ^ {SAMPLE_W{r_s1_sample[SAMPLE_W-1]}};

  assign w_msb  = r_s2_u >> r_s2_k;
  assign w_lsb  = r_s2_u & ~({SAMPLE_W{1'b1}} << r_s2_k);
  assign w_bits = {1'b0, w_msb} + OW'(r_s2_k) + OW'(1);

  always_ff @(posedge iClock) begin
    if (!iReset) begin
      r_klat      <= '0;
      r_cnt       <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_sample <= '0;
      r_s1_k      <= '0;
      r_s1_last   <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s2_u      <= '0;
      r_s2_k      <= '0;
      r_s2_last   <= 1'b0;
      oValid      <= 1'b0;
      oMSB        <= '0;
      oLSB        <= '0;
      oK          <= '0;
      oBitsUsed   <= '0;
      oLast       <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid <= w_acc;
      if (w_acc) begin
        r_s1_sample <= iSample;
        r_s1_k      <= w_k;
        r_s1_last   <= w_last;
        r_klat      <= w_k;
        r_cnt       <= w_cnt_n;
      end
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_u    <= w_u;
        r_s2_k    <= r_s1_k;
        r_s2_last <= r_s1_last;
      end
      oValid <= r_s2_valid;
      if (r_s2_valid) begin
        oMSB      <= w_msb;
        oLSB      <= w_lsb;
        oK        <= r_s2_k;
        oBitsUsed <= w_bits;
        oLast     <= r_s2_last;
      end
    end
  end

`ifdef RICE_BLOCK_BITS_EN
  logic        r_s1_first;
  logic        r_s2_first;
  logic        r_s3_first;
  logic [31:0] r_acc;
  logic [31:0] r_bb;
  logic        r_bbv;
  logic [31:0] w_sum;

  // a block-opening word restarts the sum, so abandoned blocks drop out
  assign w_sum = (r_s3_first ? 32'd0 : r_acc) + 32'(oBitsUsed);

  always_ff @(posedge iClock) begin
    if (!iReset) begin
      r_s1_first <= 1'b0;
      r_s2_first <= 1'b0;
      r_s3_first <= 1'b0;
      r_acc      <= '0;
      r_bb       <= '0;
      r_bbv      <= 1'b0;
    end else begin
      r_bbv <= 1'b0;
      if (w_adv) begin
        if (w_acc)      r_s1_first <= iStart;
        if (r_s1_valid) r_s2_first <= r_s1_first;
        if (r_s2_valid) r_s3_first <= r_s2_first;
      end
      if (oValid && iReady) begin
        if (oLast) begin
          r_bb  <= w_sum;
          r_bbv <= 1'b1;
          r_acc <= '0;
        end else begin
          r_acc <= w_sum;
        end
      end
    end
  end

  assign oBlockBits      = r_bb;
  assign oBlockBitsValid = r_bbv;
`else
  assign oBlockBits      = '0;
  assign oBlockBitsValid = 1'b0;
`endif

endmodule

// File: tb/tb_rice_encoder_param.sv
// Directed bench for rice_encoder_param with a negedge scoreboard.
// Build with or without RICE_BLOCK_BITS_EN to match the RTL build.
module tb_rice_encoder_param;

  logic               clk = 1'b0;
  logic               iReset;
  logic               iValid;
  logic               oReady;
  logic signed [15:0] iSample;
  logic               iStart;
  logic [4:0]         iK;
  logic [15:0]        iBlockLen;
  logic               oValid;
  logic               iReady;
  logic [15:0]        oMSB;
  logic [15:0]        oLSB;
  logic [4:0]         oK;
  logic [16:0]        oBitsUsed;
  logic               oLast;
  logic [31:0]        oBlockBits;
  logic               oBlockBitsValid;

  always #5 clk = ~clk;

  rice_encoder_param dut (
    .iClock(clk), .iReset(iReset), .iValid(iValid), .oReady(oReady),
    .iSample(iSample), .iStart(iStart), .iK(iK), .iBlockLen(iBlockLen),
    .oValid(oValid), .iReady(iReady), .oMSB(oMSB), .oLSB(oLSB),
    .oK(oK), .oBitsUsed(oBitsUsed), .oLast(oLast),
    .oBlockBits(oBlockBits), .oBlockBitsValid(oBlockBitsValid)
  );

  typedef struct {
    int msb;
    int lsb;
    int k;
    int bits;
    bit last;
    bit first;
  } exp_t;

  exp_t        q[$];
  int          chk = 0;
  int          err = 0;
  int          mk = 0;
  int          mcnt = 0;
  longint      macc = 0;
  bit          bb_pend = 0;
  longint      bb_exp = 0;
  bit          frz = 0;
  logic [15:0] f_msb;
  logic [15:0] f_lsb;
  logic [16:0] f_bits;
  logic [4:0]  f_k;
  logic        f_last;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    chk++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t   e;
    int     sv;
    longint u;
    if (!iReset) begin
      q.delete();
      mk = 0;
      mcnt = 0;
      macc = 0;
      bb_pend = 0;
      frz = 0;
    end else begin
      if (bb_pend) begin
        check("bb_valid", oBlockBitsValid, 1);
        check("bb_value", oBlockBits, bb_exp);
      end else begin
        check("bb_idle", oBlockBitsValid, 0);
      end
`ifndef RICE_BLOCK_BITS_EN
      check("bb_tied", oBlockBits, 0);
`endif
      bb_pend = 0;
      if (frz) begin
        check("frz_valid", oValid, 1);
        check("frz_msb", oMSB, f_msb);
        check("frz_lsb", oLSB, f_lsb);
        check("frz_bits", oBitsUsed, f_bits);
        check("frz_k", oK, f_k);
        check("frz_last", oLast, f_last);
      end
      frz = oValid && !iReady;
      f_msb = oMSB; f_lsb = oLSB; f_bits = oBitsUsed;
      f_k = oK; f_last = oLast;
      if (oValid && iReady) begin
        if (q.size() == 0) begin
          check("unexpected_out", oValid, 0);
        end else begin
          e = q.pop_front();
          check("msb", oMSB, e.msb);
          check("lsb", oLSB, e.lsb);
          check("k", oK, e.k);
          check("bits", oBitsUsed, e.bits);
          check("last", oLast, e.last);
`ifdef RICE_BLOCK_BITS_EN
          if (e.first) macc = 0;
          macc += e.bits;
          if (e.last) begin
            bb_pend = 1;
            bb_exp = macc;
            macc = 0;
          end
`endif
        end
      end
      if (iValid && oReady) begin
        if (iStart) begin
          mk = (iK > 14) ? 14 : int'(iK);
          mcnt = (iBlockLen == 0) ? 1 : int'(iBlockLen);
          e.last = (mcnt == 1);
          mcnt--;
        end else begin
          e.last = (mcnt == 1);
          if (mcnt != 0) mcnt--;
        end
        sv = int'(iSample);
        u = (sv >= 0) ? 2 * longint'(sv) : -2 * longint'(sv) - 1;
        e.k = mk;
        e.msb = int'(u >> mk);
        e.lsb = int'(u % (longint'(1) << mk));
        e.bits = e.msb + 1 + mk;
        e.first = iStart;
        q.push_back(e);
      end
    end
  end

  task automatic send(input int s, input bit st, input int k, input int len);
    int n;
    bit ok;
    n = 0;
    iValid = 1;
    iSample = 16'(s);
    iStart = st;
    iK = 5'(k);
    iBlockLen = 16'(len);
    do begin
      @(negedge clk);
      ok = oReady;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 50);
    check("accept", ok, 1);
    iStart = 0;
  endtask

  task automatic idle(input int n);
    iValid = 0;
    iStart = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!oValid && n < 20);
    check("out_seen", oValid, 1);
  endtask

  initial begin
    int vals[8] = '{100, -100, 5, -7, 0, 32767, -1, 12};
    int n;
    iReset = 0; iValid = 0; iSample = 0; iStart = 0;
    iK = 0; iBlockLen = 0; iReady = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", oValid, 0);
    check("rst_ready", oReady, 0);
    check("rst_msb", oMSB, 0);
    check("rst_lsb", oLSB, 0);
    check("rst_k", oK, 0);
    check("rst_bits", oBitsUsed, 0);
    check("rst_last", oLast, 0);
    check("rst_bb", oBlockBits, 0);
    check("rst_bbv", oBlockBitsValid, 0);
    @(posedge clk);
    #1 iReset = 1;
    @(negedge clk);
    check("rel_ready", oReady, 1);
    @(posedge clk);
    #1;

    iValid = 1; iStart = 1; iK = 0; iBlockLen = 3; iSample = 0;
    @(posedge clk);
    #1 iValid = 0; iStart = 0;
    @(negedge clk); check("lat1", oValid, 0);
    @(negedge clk); check("lat2", oValid, 0);
    @(negedge clk); check("lat3", oValid, 1);
    check("lat3_msb", oMSB, 0);
    @(posedge clk);
    #1;
    send(-1, 0, 0, 0);
    send(1, 0, 0, 0);
    idle(6);

    send(5, 1, 3, 1);
    idle(0);
    wait_out();
    check("k3_msb", oMSB, 1);
    check("k3_lsb", oLSB, 2);
    check("k3_bits", oBitsUsed, 5);
    check("k3_last", oLast, 1);
    @(posedge clk);
    #1;
    send(-32768, 1, 14, 0);
    idle(0);
    wait_out();
    check("k14_msb", oMSB, 3);
    check("k14_lsb", oLSB, 16383);
    check("k14_bits", oBitsUsed, 18);
    check("k14_last", oLast, 1);
    @(posedge clk);
    #1;
    send(100, 1, 20, 2);
    idle(0);
    wait_out();
    check("clamp_k", oK, 14);
    @(posedge clk);
    #1;
    send(200, 0, 0, 0);
    send(7, 0, 0, 0);
    idle(6);

    send(3, 1, 2, 4);
    send(-2, 0, 0, 0);
    send(0, 0, 0, 0);
    send(7, 0, 0, 0);
    idle(0);
`ifdef RICE_BLOCK_BITS_EN
    n = 0;
    while (!oBlockBitsValid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("blk_bits", oBlockBits, 16);
    @(posedge clk);
    #1;
`endif
    idle(6);

    fork
      begin
        for (int i = 0; i < 8; i++) send(vals[i], 0, 0, 0);
        idle(0);
      end
      begin
        repeat (3) @(posedge clk);
        #2 iReady = 0;
        repeat (5) begin
          @(negedge clk);
          check("stall_ready", oReady, 0);
        end
        @(posedge clk);
        #2 iReady = 1;
      end
    join
    idle(10);

    send(10, 1, 1, 8);
    send(-3, 0, 0, 0);
    send(4, 1, 5, 2);
    send(-9, 0, 0, 0);
    idle(8);

    send(1, 1, 4, 10);
    send(2, 0, 0, 0);
    send(3, 0, 0, 0);
    iValid = 0;
    iReset = 0;
    @(posedge clk);
    #1 iReset = 1;
    @(negedge clk);
    check("flush_valid", oValid, 0);
    @(posedge clk);
    #1;
    idle(6);
    send(5, 0, 0, 0);
    idle(0);
    wait_out();
    check("post_rst_k", oK, 0);
    check("post_rst_last", oLast, 0);
    @(posedge clk);
    #1;
    idle(8);
    check("sb_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule
